multiply_arbiter: RTL and testbench

Shares one `multiply` unit (ARGW=16, ARGN=2, RESW=32, valid/ready streaming) between N independent requesters. Arbitration is round-robin.
- Each accepted operand transfer is tagged with the requester index in an in-order tag FIFO.
- Each result leaving `multiply` is steered back to the requester that issued it.
- Sits between per-neuron/per-layer clients and the single shared multiplier.

---
 rtl/multiply_pkg.sv | 18 +
 rtl/multiply_tags.sv | 61 ++++++
 rtl/multiply_arbiter.sv | 125 ++++++++++++
 tb/tb_multiply_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_pkg.sv
// Shared types and helpers for the multiply sharing logic.
package multiply_pkg;

  localparam int unsigned DEFAULT_ARGW = 16;
  localparam int unsigned DEFAULT_ARGN = 2;
  localparam int unsigned DEFAULT_RESW = 32;

  typedef logic [DEFAULT_ARGN*DEFAULT_ARGW-1:0] arg_t;
  typedef logic [DEFAULT_RESW-1:0]              res_t;

  // Bits needed to name one of n requesters, never less than one.
  function automatic int unsigned tag_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multiply_tags.sv
// In-order FIFO of requester tags for transactions in flight inside multiply.
module multiply_tags
  import multiply_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_tag,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_q];
  assign count = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_tag;
  end

endmodule

// File: rtl/multiply_arbiter.sv
// Round-robin sharing of one in-order multiply unit among N requesters,
// with results steered back by an in-order tag FIFO.
module multiply_arbiter
  import multiply_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned ARGW  = DEFAULT_ARGW,
  parameter int unsigned ARGN  = DEFAULT_ARGN,
  parameter int unsigned RESW  = DEFAULT_RESW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 req_valid,
  input  logic [N*ARGN*ARGW-1:0]       req_data,
  output logic [N-1:0]                 req_ready,
  output logic [N-1:0]                 rsp_valid,
  output logic [RESW-1:0]              rsp_data,
  input  logic [N-1:0]                 rsp_ready,
  output logic                         arg_valid,
  output logic [ARGN*ARGW-1:0]         arg_data,
  input  logic                         arg_ready,
  input  logic                         res_valid,
  input  logic [RESW-1:0]              res_data,
  output logic                         res_ready,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int unsigned AW = ARGN * ARGW;
  localparam int unsigned TW = tag_width(N);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [TW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic [TW-1:0] pick, winner, head;
  logic          rr_found;
  int unsigned   rr_idx;
  logic          any_req, empty, full, push, pop;
  logic [CW-1:0] count;

  // First valid requester at or above ptr, wrapping modulo N.
  always_comb begin
    pick     = ptr_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      rr_idx = 32'(ptr_q) + i;
      if (rr_idx >= N) rr_idx = rr_idx - N;
      if (!rr_found && req_valid[TW'(rr_idx)]) begin
        pick     = TW'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  assign any_req   = |req_valid;
  assign winner    = lock_q ? lock_idx_q : pick;
  assign arg_valid = !rst && any_req && !full;
  assign arg_data  = req_data[32'(winner)*AW +: AW];
  assign push      = arg_valid && arg_ready;

  always_comb begin
    req_ready = '0;
    if (arg_valid && arg_ready) req_ready[winner] = 1'b1;
  end

  // A stalled offer freezes the grant until it is taken.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (push) begin
      ptr_d  = (winner == TW'(N - 1)) ? '0 : winner + TW'(1);
      lock_d = 1'b0;
    end else if (arg_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  multiply_tags #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (winner),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  assign rsp_data  = res_data;
  assign res_ready = !rst && !empty && rsp_ready[head];
  assign pop       = res_valid && res_ready;
  assign pending   = count;

  always_comb begin
    rsp_valid = '0;
    if (!rst && res_valid && !empty) rsp_valid[head] = 1'b1;
  end

  a_lock_held : assert property (@(posedge clk) disable iff (rst)
    lock_q |-> (req_valid[lock_idx_q] && arg_data == $past(arg_data)));

  a_no_orphan_result : assert property (@(posedge clk) disable iff (rst)
    !(res_valid && empty));

endmodule

// File: tb/tb_multiply_arbiter.sv
// Bench for multiply_arbiter with a behavioural in-order multiplier attached.
`timescale 1ns/1ps
module tb_multiply_arbiter;
  import multiply_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  res_t              rsp_data;
  logic [N-1:0]      rsp_ready = '1;
  logic              arg_valid;
  arg_t              arg_data;
  logic              mul_ready = 1'b1;
  logic              res_valid = 1'b0;
  res_t              res_data = '0;
  logic              res_ready;
  logic [CW-1:0]     pending;

  always #5 clk = ~clk;

  multiply_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .arg_valid(arg_valid), .arg_data(arg_data), .arg_ready(mul_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .pending(pending)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic res_t prod(input arg_t a);
    return res_t'(32'(a[31:16]) * 32'(a[15:0]));
  endfunction

  // In-order multiplier, one cycle of latency, flushed by the shared reset.
  res_t mq[$];
  always @(posedge clk) begin
    if (rst) mq.delete();
    else begin
      if (res_valid && res_ready) void'(mq.pop_front());
      if (arg_valid && mul_ready) mq.push_back(prod(arg_data));
    end
    res_valid <= !rst && (mq.size() > 0);
    res_data  <= (mq.size() > 0) ? mq[0] : '0;
  end

  // Expected results in issue order; each entry names who must receive it.
  typedef struct { int tag; res_t val; } exp_t;
  exp_t gq[$];
  int   grant_log[$];
  int   rsp_tag_log[$];
  res_t rsp_dat_log[$];
  logic [N-1:0] acc_mask = '0;

  always @(posedge clk) begin
    exp_t e;
    bit   popped;
    if (rst) begin
      gq.delete();
      acc_mask = '0;
    end else begin
      popped   = 1'b0;
      acc_mask = req_valid & req_ready;
      for (int i = 0; i < int'(N); i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_tag_log.push_back(i);
          rsp_dat_log.push_back(rsp_data);
          if (!popped && gq.size() > 0) void'(gq.pop_front());
          popped = 1'b1;
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (acc_mask[i]) begin
          grant_log.push_back(i);
          e.tag = i;
          e.val = prod(req_data[i*AW +: AW]);
          gq.push_back(e);
        end
      end
    end
  end

  function automatic int gl(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction
  function automatic int tl(input int k);
    return (k < rsp_tag_log.size()) ? rsp_tag_log[k] : -1;
  endfunction
  function automatic res_t dl(input int k);
    return (k < rsp_dat_log.size()) ? rsp_dat_log[k] : 32'hdead_beef;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    rsp_tag_log.delete();
    rsp_dat_log.delete();
  endtask

  task automatic send(input int idx, input arg_t d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_data[idx*AW +: AW] = d;
    req_valid[idx] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_ready[idx]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("send_accept", 64'(got), 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int idx, input res_t exp);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (rsp_valid != '0) begin got = 1'b1; break; end
    end
    chk("rsp_seen", 64'(got), 1);
    chk("rsp_target", 64'(rsp_valid), 64'(1) << idx);
    chk("rsp_data", 64'(rsp_data), 64'(exp));
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic         ar;
    logic         av;
    logic [N-1:0] rr;
    int           w;
  } vec_t;

  vec_t vt[6];
  int   issued[N];
  int   received[N];

  initial begin
    arg_t ed;
    logic [N-1:0] rv;
    logic [N-1:0] exp_rv;

    // Issue arbitration from the reset pointer.
    vt[0] = '{4'b0000, 1'b1, 1'b0, 4'b0000, -1};
    vt[1] = '{4'b0100, 1'b1, 1'b1, 4'b0100,  2};
    vt[2] = '{4'b1010, 1'b1, 1'b1, 4'b0010,  1};
    vt[3] = '{4'b1111, 1'b0, 1'b1, 4'b0000,  0};
    vt[4] = '{4'b1000, 1'b1, 1'b1, 4'b1000,  3};
    vt[5] = '{4'b1001, 1'b1, 1'b1, 4'b0001,  0};
    for (int k = 0; k < 6; k++) begin
      do_reset();
      #1;
      chk("reset_pending", 64'(pending), 0);
      chk("reset_rsp_valid", 64'(rsp_valid), 0);
      chk("reset_arg_valid", 64'(arg_valid), 0);
      for (int i = 0; i < int'(N); i++) req_data[i*AW +: AW] = {16'(i + 1), 16'(i + 7)};
      mul_ready = vt[k].ar;
      req_valid = vt[k].rv;
      #1;
      chk("vec_arg_valid", 64'(arg_valid), 64'(vt[k].av));
      chk("vec_req_ready", 64'(req_ready), 64'(vt[k].rr));
      if (vt[k].w >= 0) begin
        ed = {16'(vt[k].w + 1), 16'(vt[k].w + 7)};
        chk("vec_arg_data", 64'(arg_data), 64'(ed));
      end
      req_valid = '0;
    end

    // Single requester.
    do_reset();
    mul_ready = 1'b1; rsp_ready = '1;
    send(1, 32'h0080_0080);
    wait_rsp(1, 32'h4000);
    send(1, 32'h0100_0100);
    wait_rsp(1, 32'h10000);
    @(negedge clk); #1;
    chk("t1_pending_zero", 64'(pending), 0);

    // Round-robin with everyone asking.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < int'(N); i++) req_data[i*AW +: AW] = {16'(i + 1), 16'h0002};
    req_valid = '1;
    repeat (5) @(posedge clk);
    #1 req_valid = '0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 5; k++) chk("t2_grant_order", 64'(gl(k)), 64'(k % 4));
    for (int k = 0; k < 4; k++) begin
      chk("t2_rsp_tag", 64'(tl(k)), 64'(k));
      chk("t2_rsp_data", 64'(dl(k)), 64'(2 * (k + 1)));
    end

    // Grant lock across a stall.
    do_reset();
    mul_ready = 1'b0;
    @(negedge clk);
    req_data[2*AW +: AW] = 32'h0003_0004;
    req_valid[2] = 1'b1;
    #1;
    chk("t3_arg_valid", 64'(arg_valid), 1);
    chk("t3_arg_data", 64'(arg_data), 64'h0003_0004);
    @(negedge clk);
    req_data[0*AW +: AW] = 32'h0005_0006;
    req_valid[0] = 1'b1;
    #1;
    chk("t3_lock_data", 64'(arg_data), 64'h0003_0004);
    chk("t3_lock_no_ready", 64'(req_ready), 0);
    @(negedge clk); #1;
    chk("t3_lock_data2", 64'(arg_data), 64'h0003_0004);
    @(negedge clk);
    mul_ready = 1'b1;
    #1;
    chk("t3_locked_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    @(negedge clk); #1;
    chk("t3_next_grant", 64'(req_ready), 64'b0001);
    chk("t3_next_data", 64'(arg_data), 64'h0005_0006);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_grant0", 64'(gl(0)), 2);
    chk("t3_grant1", 64'(gl(1)), 0);
    chk("t3_res0", 64'(dl(0)), 12);
    chk("t3_res1", 64'(dl(1)), 30);

    // Full, and no pop-through.
    do_reset();
    rsp_ready = '0; mul_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(N); i++) req_data[i*AW +: AW] = {16'(i + 1), 16'h0003};
    req_valid = '1;
    repeat (4) @(posedge clk);
    #1 req_valid = 4'b0001;
    @(negedge clk); #1;
    chk("t4_pending_full", 64'(pending), 4);
    chk("t4_arg_valid_off", 64'(arg_valid), 0);
    chk("t4_no_ready", 64'(req_ready), 0);
    chk("t4_grants", 64'(grant_log.size()), 4);
    chk("t4_head_valid", 64'(rsp_valid), 64'b0001);
    @(negedge clk); #1;
    chk("t4_still_full", 64'(pending), 4);
    @(negedge clk);
    rsp_ready = 4'b0001;
    #1;
    chk("t4_no_pop_through", 64'(arg_valid), 0);
    chk("t4_res_ready", 64'(res_ready), 1);
    @(posedge clk); #1 rsp_ready = '0;
    @(negedge clk); #1;
    chk("t4_after_pop", 64'(pending), 3);
    chk("t4_fifth_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); #1;
    chk("t4_refull", 64'(pending), 4);
    chk("t4_fifth_grant", 64'(gl(4)), 0);
    chk("t4_first_res", 64'(dl(0)), 3);

    // Head-of-line blocking.
    do_reset();
    rsp_ready = 4'b0010; mul_ready = 1'b1;
    send(0, 32'h7fff_0000);
    send(1, 32'h0003_0003);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("t5_hol_valid", 64'(rsp_valid), 64'b0001);
      chk("t5_hol_data", 64'(rsp_data), 0);
    end
    @(negedge clk);
    rsp_ready = 4'b0011;
    #1;
    chk("t5_release", 64'(res_ready), 1);
    wait_rsp(1, 32'd9);
    chk("t5_order0", 64'(tl(0)), 0);

    // Reset while transactions are in flight.
    do_reset();
    rsp_ready = '0; mul_ready = 1'b1;
    send(0, 32'h0002_0002);
    send(1, 32'h0002_0003);
    send(2, 32'h0002_0004);
    @(negedge clk); #1;
    chk("t6_pending3", 64'(pending), 3);
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b1000; rsp_ready = '1;
    #1;
    chk("t6_rst_arg_valid", 64'(arg_valid), 0);
    chk("t6_rst_req_ready", 64'(req_ready), 0);
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 0);
    chk("t6_rst_res_ready", 64'(res_ready), 0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    #1;
    chk("t6_pending0", 64'(pending), 0);
    chk("t6_rsp_valid0", 64'(rsp_valid), 0);
    rsp_tag_log.delete(); rsp_dat_log.delete();
    send(3, 32'h0080_0080);
    wait_rsp(3, 32'h4000);
    @(negedge clk); #1;
    chk("t6_one_result", 64'(rsp_tag_log.size()), 1);
    chk("t6_pending_end", 64'(pending), 0);

    // Random traffic against the issue-order scoreboard.
    do_reset();
    rv = '0;
    for (int i = 0; i < int'(N); i++) begin issued[i] = 0; received[i] = 0; end
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      rv = req_valid & ~acc_mask;
      for (int i = 0; i < int'(N); i++) begin
        if (!rv[i] && c < 600 && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          req_data[i*AW +: AW] = $urandom;
          issued[i]++;
        end
      end
      req_valid = rv;
      rsp_ready = (c < 600) ? N'($urandom) : '1;
      mul_ready = (c < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      exp_rv = (res_valid && gq.size() > 0) ? N'(1 << gq[0].tag) : '0;
      chk("rand_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv != '0) chk("rand_rsp_data", 64'(rsp_data), 64'(gq[0].val));
      chk("rand_pending", 64'(pending), 64'(gq.size()));
      chk("rand_grant_legal", 64'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
    end
    foreach (rsp_tag_log[k]) received[rsp_tag_log[k]]++;
    for (int i = 0; i < int'(N); i++) chk("rand_served", 64'(received[i]), 64'(issued[i]));
    chk("rand_drained", 64'(pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
